output_mem_ctrl: RTL and testbench

Sequences the 256-word output result memory for one matrix job. During FILL it accepts finished 4x4 tiles from the systolic array and issues one 16-word save per tile at consecutive 16-word bases. During DRAIN it reads the stored words back in address order and streams them out on a valid/ready interface, fully absorbing the memory's 1-cycle registered read latency.

---
 rtl/output_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_output_mem_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/output_mem_ctrl.sv
// Output result memory sequencer: FILL stores 4x4 tiles at consecutive 16-word
// bases, DRAIN streams the stored words out over valid/ready.
module output_mem_ctrl #(
    parameter int TILE_WORDS = 16,
    parameter int MAX_TILES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  num_tiles,
    input  logic        tile_valid,
    output logic        tile_ready,
    output logic        save_into_memory,
    output logic [7:0]  save_base_memory,
    output logic [7:0]  addrO,
    input  logic [15:0] mem_dataO,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t      state_r, state_nxt_s;
    logic [4:0]  n_r, n_nxt_s;
    logic [4:0]  wr_tile_r, wr_tile_nxt_s;
    logic [7:0]  rd_addr_r, rd_addr_nxt_s;
    logic        primed_r, primed_nxt_s;
    logic [4:0]  n_clamp_s;
    logic [8:0]  last_addr_s;
    logic        fire_s;

    assign n_clamp_s   = (num_tiles > 5'(MAX_TILES)) ? 5'(MAX_TILES) : num_tiles;
    // Nine bits so a full 16-tile job yields 255 without wrapping.
    assign last_addr_s = 9'(9'(n_r) * 9'(TILE_WORDS)) - 9'd1;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            n_r       <= 5'd0;
            wr_tile_r <= 5'd0;
            rd_addr_r <= 8'd0;
            primed_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            n_r       <= n_nxt_s;
            wr_tile_r <= wr_tile_nxt_s;
            rd_addr_r <= rd_addr_nxt_s;
            primed_r  <= primed_nxt_s;
        end
    end

    // Next-state logic and all outputs.
    always_comb begin
        state_nxt_s      = state_r;
        n_nxt_s          = n_r;
        wr_tile_nxt_s    = wr_tile_r;
        rd_addr_nxt_s    = rd_addr_r;
        primed_nxt_s     = primed_r;
        tile_ready       = 1'b0;
        save_into_memory = 1'b0;
        save_base_memory = 8'd0;
        addrO            = 8'd0;
        out_data         = 16'd0;
        out_valid        = 1'b0;
        out_last         = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        fire_s           = 1'b0;
        case (state_r)
            IDLE: begin
                primed_nxt_s = 1'b0;
                if (start) begin
                    n_nxt_s = n_clamp_s;
                    if (n_clamp_s == 5'd0) begin
                        state_nxt_s = DONE;
                    end else begin
                        wr_tile_nxt_s = 5'd0;
                        state_nxt_s   = FILL;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                busy             = 1'b1;
                tile_ready       = 1'b1;
                save_into_memory = tile_valid;
                save_base_memory = 8'(wr_tile_r) * 8'(TILE_WORDS);
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (tile_valid) begin
                    wr_tile_nxt_s = wr_tile_r + 5'd1;
                    if (wr_tile_r == n_r - 5'd1) begin
                        state_nxt_s   = DRAIN;
                        rd_addr_nxt_s = 8'd0;
                        primed_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = FILL;
                end
            end
            DRAIN: begin
                busy         = 1'b1;
                primed_nxt_s = 1'b1;
                out_valid    = primed_r;
                out_data     = primed_r ? mem_dataO : 16'd0;
                fire_s       = primed_r & out_ready;
                // Holding the address while stalled keeps mem_dataO stable.
                addrO        = fire_s ? rd_addr_r + 8'd1 : rd_addr_r;
                out_last     = primed_r & ({1'b0, rd_addr_r} == last_addr_s);
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (fire_s) begin
                    rd_addr_nxt_s = rd_addr_r + 8'd1;
                    if ({1'b0, rd_addr_r} == last_addr_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                done        = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_output_mem_ctrl.sv
// Self-checking bench for output_mem_ctrl with a behavioural result memory.
module tb_output_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, tile_valid, out_ready;
    logic [4:0]  num_tiles;
    logic        tile_ready, save_into_memory, out_valid, out_last, busy, done;
    logic [7:0]  save_base_memory, addrO;
    logic [15:0] mem_dataO, out_data;

    int checks = 0;
    int fails  = 0;
    int cur_job = 0;
    logic [15:0] mem [256];

    always #5 clk = ~clk;

    output_mem_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_tiles(num_tiles),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .save_into_memory(save_into_memory), .save_base_memory(save_base_memory),
        .addrO(addrO), .mem_dataO(mem_dataO), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    function automatic logic [15:0] pat(int job, int a);
        return 16'((job * 4099) ^ (a * 37));
    endfunction

    // Result memory: 16-word tile write, 1-cycle registered read.
    always @(posedge clk) begin
        if (save_into_memory) begin
            for (int i = 0; i < 16; i++)
                mem[int'(save_base_memory) + i] <= pat(cur_job, int'(save_base_memory) + i);
        end
        mem_dataO <= mem[addrO];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int ntiles;
        int bp;
        int job;
        int exp_saves;
        int exp_words;
        int exp_last;
        bit mid_start;
    } vec_t;

    vec_t vecs [5];

    task automatic run_job(input vec_t v);
        int saves, words, valid_cycles, dones, last_save_cyc, first_valid_cyc;
        bit stalled, finished;
        logic [15:0] held;
        saves = 0; words = 0; valid_cycles = 0; dones = 0;
        last_save_cyc = -1; first_valid_cyc = -1;
        stalled = 1'b0; finished = 1'b0; held = 16'd0;
        cur_job = v.job;
        @(negedge clk);
        start = 1'b1; num_tiles = 5'(v.ntiles); tile_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2000 && !finished; k++) begin
            tile_valid = (v.bp == 0) ? 1'b1 : (k % 2 == 0);
            out_ready  = (v.bp == 0) ? 1'b1 : (k % 3 == 0);
            if (v.mid_start && words == 5) begin
                start = 1'b1; num_tiles = 5'd0;
            end else begin
                start = 1'b0;
            end
            #1;
            if (save_into_memory) begin
                check("save_base", save_base_memory, saves * 16);
                saves++;
                last_save_cyc = k;
            end
            if (out_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = k;
                if (stalled) check("stall_hold", out_data, held);
                if (out_ready) begin
                    check("out_data", out_data, pat(v.job, words));
                    check("out_last", out_last, words == v.exp_last);
                    words++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end
            if (done) begin
                dones++;
                finished = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0; tile_valid = 1'b0; out_ready = 1'b0;
        check("timeout", finished, 1);
        check("saves", saves, v.exp_saves);
        check("words", words, v.exp_words);
        check("dones", dones, 1);
        if (v.exp_words > 0) check("first_valid_latency", first_valid_cyc - last_save_cyc, 2);
        else check("no_valid", valid_cycles, 0);
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'hDEAD;
        vecs[0] = '{2,  0, 1, 2,  32,  31,  1'b1};
        vecs[1] = '{16, 0, 2, 16, 256, 255, 1'b0};
        vecs[2] = '{20, 0, 3, 16, 256, 255, 1'b0};
        vecs[3] = '{1,  1, 4, 1,  16,  15,  1'b0};
        vecs[4] = '{0,  0, 5, 0,  0,   0,   1'b0};

        // Reset has priority over a simultaneous start.
        rst = 1'b1; start = 1'b1; abort = 1'b0; num_tiles = 5'd3;
        tile_valid = 1'b1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_tile_ready", tile_ready, 0);
        check("rst_save", save_into_memory, 0);
        check("rst_save_base", save_base_memory, 0);
        check("rst_addr", addrO, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b1; tile_valid = 1'b1;
        #1;
        check("idle_tile_ready", tile_ready, 0);
        check("idle_save", save_into_memory, 0);
        @(negedge clk); #1;
        check("idle_abort_busy", busy, 0);
        abort = 1'b0; tile_valid = 1'b0;

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        // Abort after the first of three tiles.
        cur_job = 8;
        @(negedge clk);
        start = 1'b1; num_tiles = 5'd3; tile_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; tile_valid = 1'b1;
        #1;
        check("abort_save", save_into_memory, 1);
        check("abort_base", save_base_memory, 0);
        @(negedge clk);
        tile_valid = 1'b0; abort = 1'b1;
        #1;
        check("abort_busy_before", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy_after", busy, 0);
        check("abort_no_done", done, 0);
        @(negedge clk); #1;
        check("abort_no_done_later", done, 0);

        // A fresh job after the abort must start again at base 0.
        run_job('{1, 0, 9, 1, 16, 15, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
